machtru_serial: RTL and testbench
=================================

MACHTRU_SERIAL -- requirements
Module: machtru_serial

Interface
REQ-001 Parameter WIDTH, default 8; operand width in bits; legal values 2..64.
REQ-002 Parameter STEP, default 1; bits subtracted per clock; legal values divide WIDTH exactly.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  request a subtraction; honoured only in IDLE.
REQ-006 X  input  WIDTH  minuend; sampled on the accepting edge only.
REQ-007 Y  input  WIDTH  subtrahend; sampled on the accepting edge only.
REQ-008 bin  input  1  borrow-in into bit 0; sampled on the accepting edge only.
REQ-009 busy  output  1  high while a subtraction is in progress.
REQ-010 done  output  1  one-cycle pulse when the result is valid.
REQ-011 B  output  WIDTH+1  result; B[WIDTH-1:0] = difference, B[WIDTH] = final borrow-out.
REQ-012 ovf  output  1  two's-complement signed overflow of the WIDTH-bit difference.

Function
REQ-013 FSM states: IDLE and RUN only.
REQ-014 IDLE with start=1: latch X, Y and bin; clear the working difference; load the step counter with WIDTH/STEP; go to RUN; busy=1 from the next cycle.
REQ-015 IDLE with start=0: hold all outputs, including the last B and ovf.
REQ-016 RUN, each cycle: subtract the next STEP-bit slice LSB-first (slice_x - slice_y - borrow); write the slice result into the difference; register the borrow for the next slice; decrement the counter.
REQ-017 Final RUN cycle (counter=1): go to IDLE; busy=0; done=1 for exactly one cycle.
REQ-018 On that final cycle, update B and ovf together; they are stable while done=1 and held until the next accepted start.
REQ-019 Latency: start accepted on edge k gives done=1 and valid B in the cycle after edge k+WIDTH/STEP; busy is high for exactly WIDTH/STEP cycles.
REQ-020 B equals (X - Y - bin) mod 2^(WIDTH+1) with X and Y zero-extended; B[WIDTH]=1 exactly when X < Y+bin as unsigned values.
REQ-021 ovf = (X[WIDTH-1] != Y[WIDTH-1]) AND (B[WIDTH-1] != X[WIDTH-1]), using the latched operands.
REQ-022 start while in RUN is ignored; no re-latch and no abort; X, Y and bin may change freely during RUN without affecting the result.
REQ-023 start=1 in the same cycle as done=1 (state IDLE): accepted; back-to-back operations have no dead cycle.
REQ-024 B and ovf do not change during RUN; the internal working difference is separate from B.
REQ-025 STEP=WIDTH is legal: one RUN cycle, latency 1.

Reset
REQ-026 rst=1 on a rising edge forces, at that edge: IDLE; busy=0; done=0; B=0; ovf=0; counter, working difference and borrow cleared.
REQ-027 rst has priority over start and over an operation in progress; a reset during RUN aborts it and produces no done pulse.
REQ-028 After rst deasserts, the first accepted start behaves exactly as after power-up reset.

Verification (WIDTH=8, STEP=1 unless stated)
REQ-029 X=0x05, Y=0x03, bin=0, start pulse -> busy for 8 cycles; done pulse; B=9'h002; ovf=0.
REQ-030 X=0x03, Y=0x05, bin=0 -> B=9'h1FE; ovf=0. Then X=0x00, Y=0x00, bin=1 -> B=9'h1FF.
REQ-031 X=0x80, Y=0x01 -> B=9'h07F; ovf=1. Then X=0x7F, Y=0xFF -> B=9'h180; ovf=1.
REQ-032 Start X=0x10, Y=0x01; at RUN cycle 3 drive start=1 with X=0xFF, Y=0x00 -> second request ignored; B=9'h00F. Then start again on the done cycle -> next result follows after 8 more cycles with no gap.
REQ-033 Assert rst at RUN cycle 4 of X=0x20, Y=0x01 -> busy=0, B=0, no done pulse; a following X=0x09, Y=0x04 -> B=9'h005.
REQ-034 WIDTH=16, STEP=4, X=0x1234, Y=0x4321 -> busy for 4 cycles; B=17'h1CF13; ovf=0. Run randomized operands against the REQ-020 reference for STEP in {1,2,4,8}.

Source files
------------

// File: rtl/machtru_serial.sv
// machtru_serial: serial subtractor producing X - Y - bin, STEP bits per clock, LSB slice first.
// Ports:
//   clk, rst      single clock; synchronous active-high reset
//   start         request, honoured only when idle; X, Y, bin are latched on that edge
//   busy          high while a subtraction is running (WIDTH/STEP cycles)
//   done          one-cycle pulse when B and ovf carry the new result
//   B             {final borrow-out, WIDTH-bit difference}, held until the next result
//   ovf           two's-complement overflow of the WIDTH-bit difference
module machtru_serial #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   B,
    output logic             ovf
);
    localparam int NSL = WIDTH / STEP;
    localparam int CW  = $clog2(NSL + 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_x, r_y, r_diff, w_diff_next;
    logic [WIDTH:0]   r_b;
    logic [CW-1:0]    r_cnt;
    logic [STEP:0]    w_sub;
    logic             r_xs, r_ys, r_brw, r_done, r_ovf;
    logic             w_accept, w_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Operands shift right so the active slice is always at bit 0; the
    // difference fills from the top so slice 0 lands at bit 0 at the end.
    // Sign bits are kept aside because the shifting destroys them.
    always_comb begin
        w_accept     = (r_state == IDLE) && start;
        w_last       = (r_state == RUN) && (r_cnt == CW'(1));
        w_state_next = w_accept ? RUN : (w_last ? IDLE : r_state);
        w_sub        = {1'b0, r_x[STEP-1:0]} - {1'b0, r_y[STEP-1:0]} - {{STEP{1'b0}}, r_brw};
        w_diff_next  = (r_diff >> STEP) | (WIDTH'(w_sub[STEP-1:0]) << (WIDTH - STEP));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_xs   <= 1'b0;
            r_ys   <= 1'b0;
            r_brw  <= 1'b0;
            r_diff <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_x    <= X;
            r_y    <= Y;
            r_xs   <= X[WIDTH-1];
            r_ys   <= Y[WIDTH-1];
            r_brw  <= bin;
            r_diff <= '0;
            r_cnt  <= CW'(NSL);
        end else if (r_state == RUN) begin
            r_x    <= r_x >> STEP;
            r_y    <= r_y >> STEP;
            r_brw  <= w_sub[STEP];
            r_diff <= w_diff_next;
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    // B and ovf only move on the final slice, so they stay stable through RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
            r_b    <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_last) begin
                r_b   <= {w_sub[STEP], w_diff_next};
                r_ovf <= (r_xs != r_ys) && (w_diff_next[WIDTH-1] != r_xs);
            end
        end
    end

    assign busy = (r_state == RUN);
    assign done = r_done;
    assign B    = r_b;
    assign ovf  = r_ovf;
endmodule

// File: tb/tb_machtru_serial.sv
// tb_machtru_serial: several widths/steps driven in parallel, compared each cycle to an arithmetic model.
module tb_machtru_serial;
    localparam int NC = 5;
    localparam int WT[NC] = '{8, 16, 16, 16, 16};
    localparam int ST[NC] = '{1, 1, 2, 4, 8};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] i_x = '0;
    logic [15:0] i_y = '0;
    logic        bin = 1'b0;
    logic        armed = 1'b0;
    int          checks = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    for (genvar g = 0; g < NC; g++) begin : g_c
        localparam int W = WT[g];
        localparam int S = ST[g];
        localparam int N = W / S;
        logic         w_busy, w_done, w_ovf;
        logic [W:0]   w_b;
        int           rem;
        logic [W:0]   eb, pb;
        logic         eo, po, ed;

        machtru_serial #(.WIDTH(W), .STEP(S)) u_dut (
            .clk(clk), .rst(rst), .start(start),
            .X(i_x[W-1:0]), .Y(i_y[W-1:0]), .bin(bin),
            .busy(w_busy), .done(w_done), .B(w_b), .ovf(w_ovf)
        );

        // Unsigned difference modulo 2^(W+1): the top bit is the borrow.
        function automatic logic [W:0] ref_b(longint x, longint y, longint b);
            longint d = x - y - b;
            if (d < 0) d += longint'(1) << (W + 1);
            return d[W:0];
        endfunction

        // Overflow: the true signed difference falls outside the W-bit range.
        function automatic logic ref_ovf(longint x, longint y, longint b);
            longint h  = longint'(1) << (W - 1);
            longint sx = (x >= h) ? x - 2 * h : x;
            longint sy = (y >= h) ? y - 2 * h : y;
            longint r  = sx - sy - b;
            return (r < -h) || (r >= h);
        endfunction

        always @(posedge clk) begin
            if (rst) begin
                rem <= 0;
                eb  <= '0;
                eo  <= 1'b0;
                ed  <= 1'b0;
            end else begin
                ed <= (rem == 1);
                if (rem == 1) begin
                    eb <= pb;
                    eo <= po;
                end
                if (rem > 0) rem <= rem - 1;
                else if (start) begin
                    rem <= N;
                    pb  <= ref_b(longint'(i_x[W-1:0]), longint'(i_y[W-1:0]), longint'(bin));
                    po  <= ref_ovf(longint'(i_x[W-1:0]), longint'(i_y[W-1:0]), longint'(bin));
                end
            end
        end

        always @(negedge clk) begin
            if (armed) begin
                chk($sformatf("c%0d_busy", g), 64'(w_busy), 64'(rem > 0));
                chk($sformatf("c%0d_done", g), 64'(w_done), 64'(ed));
                chk($sformatf("c%0d_B", g), 64'(w_b), 64'(eb));
                chk($sformatf("c%0d_ovf", g), 64'(w_ovf), 64'(eo));
            end
        end
    end

    task automatic go(input logic [15:0] x, input logic [15:0] y, input logic b);
        start = 1'b1;
        i_x   = x;
        i_y   = y;
        bin   = b;
        @(negedge clk);
        start = 1'b0;
        i_x   = 16'($urandom);
        i_y   = 16'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic wait_done(input int k, output int nb);
        nb = 0;
        for (int i = 0; i < 80; i++) begin
            if (k == 0 ? g_c[0].w_done : g_c[3].w_done) return;
            if (k == 0 ? g_c[0].w_busy : g_c[3].w_busy) nb++;
            @(negedge clk);
        end
        chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic run8(input logic [15:0] x, input logic [15:0] y, input logic b,
                        input logic [63:0] exb, input logic exo, input string nm);
        int nb;
        go(x, y, b);
        wait_done(0, nb);
        chk({nm, "_busy_cycles"}, 64'(nb), 64'd8);
        chk({nm, "_B"}, 64'(g_c[0].w_b), exb);
        chk({nm, "_ovf"}, 64'(g_c[0].w_ovf), 64'(exo));
    endtask

    initial begin
        int  nb;
        logic seen;
        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("reset_B", 64'(g_c[0].w_b), 64'd0);
        chk("reset_busy", 64'(g_c[0].w_busy), 64'd0);
        chk("reset_done", 64'(g_c[0].w_done), 64'd0);
        chk("reset_ovf", 64'(g_c[0].w_ovf), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        go(16'h1234, 16'h4321, 1'b0);
        wait_done(3, nb);
        chk("w16s4_busy_cycles", 64'(nb), 64'd4);
        chk("w16s4_B", 64'(g_c[3].w_b), 64'h1CF13);
        chk("w16s4_ovf", 64'(g_c[3].w_ovf), 64'd0);
        wait_done(0, nb);

        run8(16'h05, 16'h03, 1'b0, 64'h002, 1'b0, "sub_5_3");
        run8(16'h03, 16'h05, 1'b0, 64'h1FE, 1'b0, "sub_3_5");
        run8(16'h00, 16'h00, 1'b1, 64'h1FF, 1'b0, "sub_0_0_bin");
        run8(16'h80, 16'h01, 1'b0, 64'h07F, 1'b1, "sub_80_01");
        run8(16'h7F, 16'hFF, 1'b0, 64'h180, 1'b1, "sub_7F_FF");

        go(16'h10, 16'h01, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        i_x   = 16'hFF;
        i_y   = 16'h00;
        @(negedge clk);
        start = 1'b0;
        wait_done(0, nb);
        chk("ignore_start_B", 64'(g_c[0].w_b), 64'h00F);
        run8(16'h22, 16'h11, 1'b0, 64'h011, 1'b0, "back_to_back");

        go(16'h20, 16'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 64'(g_c[0].w_busy), 64'd0);
        chk("abort_B", 64'(g_c[0].w_b), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            seen |= g_c[0].w_done;
            @(negedge clk);
        end
        chk("abort_no_done", 64'(seen), 64'd0);
        run8(16'h09, 16'h04, 1'b0, 64'h005, 1'b0, "after_abort");

        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 2) != 0);
            i_x   = 16'($urandom);
            i_y   = 16'($urandom);
            bin   = 1'($urandom);
            case ($urandom_range(0, 7))
                0: i_x = 16'hFFFF;
                1: i_y = 16'hFFFF;
                2: i_x = i_y;
                3: i_x = 16'h8000;
                4: i_y = 16'h7FFF;
                default: ;
            endcase
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
